// File: rtl/datapath_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | datapath_ctrl_pkg                                                        |
// | Shared state encoding, opcodes, ALU codes and control-bit positions for  |
// | the hardwired datapath sequencer.                                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package datapath_ctrl_pkg;

  // Control steps: fetch T0-T2, execute/writeback T3-T6.
  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    HALT = 4'd8
  } state_t;

  // Opcodes (IR[31:27]).
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHRA = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_ROR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  // ALU operation select values.
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SHR  = 4'd5;
  localparam logic [3:0] ALU_SHRA = 4'd6;
  localparam logic [3:0] ALU_SHL  = 4'd7;
  localparam logic [3:0] ALU_ROR  = 4'd8;
  localparam logic [3:0] ALU_ROL  = 4'd9;
  localparam logic [3:0] ALU_NEG  = 4'd10;
  localparam logic [3:0] ALU_NOT  = 4'd11;
  localparam logic [3:0] ALU_MUL  = 4'd12;
  localparam logic [3:0] ALU_DIV  = 4'd13;

  // Register load-enable bit positions.
  localparam int EN_HI  = 16;
  localparam int EN_LO  = 17;
  localparam int EN_PC  = 20;
  localparam int EN_MDR = 21;
  localparam int EN_IR  = 23;
  localparam int EN_Z   = 24;
  localparam int EN_MAR = 25;
  localparam int EN_Y   = 27;

  // Bus driver bit positions.
  localparam int BS_ZHI = 18;
  localparam int BS_ZLO = 19;
  localparam int BS_PC  = 20;
  localparam int BS_MDR = 21;

  // Maps an opcode to its ALU operation; non-ALU opcodes give ALU_NONE.
  function automatic logic [3:0] op_to_alu(input logic [4:0] op);
    logic [3:0] code;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      OP_SHR:  code = ALU_SHR;
      OP_SHRA: code = ALU_SHRA;
      OP_SHL:  code = ALU_SHL;
      OP_ROR:  code = ALU_ROR;
      OP_ROL:  code = ALU_ROL;
      OP_NEG:  code = ALU_NEG;
      OP_NOT:  code = ALU_NOT;
      OP_MUL:  code = ALU_MUL;
      OP_DIV:  code = ALU_DIV;
      default: code = ALU_NONE;
    endcase
    return code;
  endfunction

  // Three-register ALU instructions.
  function automatic logic is_rtype(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_ROL);
  endfunction

  // Instructions producing a HI/LO result pair.
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Single-operand ALU instructions.
  function automatic logic is_negnot(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/datapath_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | datapath_sequencer                                                       |
// | Hardwired control unit: steps the datapath through fetch (T0-T2) and     |
// | execute/writeback (T3-T6), one control step per clock.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module datapath_sequencer
  import datapath_ctrl_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               run,
  input  logic               mem_ready,
  input  logic [31:0]        ir_in,
  output logic [31:0]        enable,
  output logic [31:0]        busSelect,
  output logic [3:0]         Control_Signals,
  output logic               MD_Read,
  output logic               pc_inc,
  output logic               halted,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  state_t             r_state;
  state_t             w_next;
  state_t             w_boundary;
  logic [COUNT_W-1:0] r_count;
  logic               w_retire;

  logic [4:0]         w_op;
  logic [3:0]         w_ra;
  logic [3:0]         w_rb;
  logic [3:0]         w_rc;
  logic               w_unused_ir;

  // IR fields are decoded live; the low bits carry immediates not used here.
  assign w_op        = ir_in[31:27];
  assign w_ra        = ir_in[26:23];
  assign w_rb        = ir_in[22:19];
  assign w_rc        = ir_in[18:15];
  assign w_unused_ir = ^ir_in[14:0];

  // Where the sequencer goes once an instruction is finished.
  assign w_boundary  = run ? T0 : IDLE;

  assign instr_count = r_count;

  // State register; clr overrides everything, including mid-instruction.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Retired-instruction counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (w_retire) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

  // Next-state and Moore control decode from the current step and live IR.
  always_comb begin
    w_next          = r_state;
    w_retire        = 1'b0;
    enable          = 32'd0;
    busSelect       = 32'd0;
    Control_Signals = ALU_NONE;
    MD_Read         = 1'b0;
    pc_inc          = 1'b0;
    halted          = 1'b0;
    illegal         = 1'b0;

    case (r_state)
      IDLE: begin
        if (run) begin
          w_next = T0;
        end
      end

      // PC -> MAR, request PC increment.
      T0: begin
        busSelect[BS_PC] = 1'b1;
        enable[EN_MAR]   = 1'b1;
        pc_inc           = 1'b1;
        w_next           = T1;
      end

      // Memory -> MDR; hold here until the memory says the data is valid.
      T1: begin
        MD_Read        = 1'b1;
        enable[EN_MDR] = 1'b1;
        if (mem_ready) begin
          w_next = T2;
        end
      end

      // MDR -> IR.
      T2: begin
        busSelect[BS_MDR] = 1'b1;
        enable[EN_IR]     = 1'b1;
        w_next            = T3;
      end

      // First execute step: load the first operand or finish short ops.
      T3: begin
        if (is_rtype(w_op)) begin
          busSelect[w_rb] = 1'b1;
          enable[EN_Y]    = 1'b1;
          w_next          = T4;
        end else if (is_muldiv(w_op)) begin
          busSelect[w_ra] = 1'b1;
          enable[EN_Y]    = 1'b1;
          w_next          = T4;
        end else if (is_negnot(w_op)) begin
          busSelect[w_rb] = 1'b1;
          enable[EN_Z]    = 1'b1;
          Control_Signals = op_to_alu(w_op);
          w_next          = T5;
        end else if (w_op == OP_NOP) begin
          w_retire = 1'b1;
          w_next   = w_boundary;
        end else if (w_op == OP_HALT) begin
          w_next = HALT;
        end else begin
          illegal = 1'b1;
          w_next  = w_boundary;
        end
      end

      // Second operand onto the bus, ALU result captured in Z.
      T4: begin
        if (is_muldiv(w_op)) begin
          busSelect[w_rb] = 1'b1;
        end else begin
          busSelect[w_rc] = 1'b1;
        end
        enable[EN_Z]    = 1'b1;
        Control_Signals = op_to_alu(w_op);
        w_next          = T5;
      end

      // Zlow writeback: to Ra for single-result ops, to LO for MUL/DIV.
      T5: begin
        busSelect[BS_ZLO] = 1'b1;
        if (is_muldiv(w_op)) begin
          enable[EN_LO] = 1'b1;
          w_next        = T6;
        end else begin
          enable[w_ra] = 1'b1;
          w_retire     = 1'b1;
          w_next       = w_boundary;
        end
      end

      // Zhigh -> HI completes MUL/DIV.
      T6: begin
        busSelect[BS_ZHI] = 1'b1;
        enable[EN_HI]     = 1'b1;
        w_retire          = 1'b1;
        w_next            = w_boundary;
      end

      // Parked until clr.
      HALT: begin
        halted = 1'b1;
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
